// File: rtl/hex5_display_arbiter_if.sv
// Requester/display bundle between the per-function lab blocks and the HEX5 arbiter.
// Latency: none, wires only.
// Backpressure: none, requesters hold req until they see their grant bit.
interface hex5_display_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] digit;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [6:0]        HEX5;
    logic [NREQ-1:0]   LEDR;

    // Requester side: drives requests and digits, watches grants and the display.
    modport master (
        output req, digit,
        input  grant, busy, HEX5, LEDR
    );

    // Arbiter side.
    modport slave (
        input  req, digit,
        output grant, busy, HEX5, LEDR
    );
endinterface

// File: rtl/hex5_display_arbiter.sv
// Round-robin owner of HEX5/LEDR: one requester at a time, digit latched and decoded for HOLD_CYCLES.
// Latency: grant/HEX5 valid one edge after req is sampled; back-to-back grants are contiguous.
// Backpressure: losing requesters simply keep req high; req/digit are ignored while a grant is held.
module hex5_display_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    hex5_display_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [PW:0]   NREQ_W    = (PW+1)'(NREQ);
    localparam logic [6:0]    BLANK     = 7'b1111111;

    typedef enum logic {IDLE, SHOW} state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   gidx_q;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] grant_q;
    logic [6:0]      hex_q;

    logic [PW:0]     nxt_sum_d;
    logic [PW:0]     scan_d;
    logic [PW-1:0]   next_ptr_d;
    logic [PW-1:0]   base_d;
    logic [PW-1:0]   win_d;
    logic            found_d;
    logic [3:0]      sel_digit_d;
    logic [6:0]      glyph_d;
    logic [NREQ-1:0] grant_new_d;

    // Active-low hex glyphs, segment order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Pick the winner: scan from ptr (or from the slot after the current owner when a
    // hold is ending, so the pointer update and re-arbitration happen on the same edge).
    always_comb begin
        nxt_sum_d = {1'b0, gidx_q} + (PW+1)'(1);
        if (nxt_sum_d >= NREQ_W) nxt_sum_d = nxt_sum_d - NREQ_W;
        next_ptr_d = nxt_sum_d[PW-1:0];
        base_d     = (state_q == SHOW) ? next_ptr_d : ptr_q;
        found_d    = 1'b0;
        win_d      = base_d;
        scan_d     = '0;
        for (int off = 0; off < NREQ; off++) begin
            scan_d = {1'b0, base_d} + (PW+1)'(off);
            if (scan_d >= NREQ_W) scan_d = scan_d - NREQ_W;
            if (!found_d && bus.req[scan_d[PW-1:0]]) begin
                found_d = 1'b1;
                win_d   = scan_d[PW-1:0];
            end
        end
        sel_digit_d = bus.digit[4*win_d +: 4];
        glyph_d     = decode(sel_digit_d);
        grant_new_d = NREQ'(1) << win_d;
    end

    // IDLE/SHOW controller; grant, glyph, pointer and hold counter are all registered here.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            hex_q   <= BLANK;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        state_q <= SHOW;
                        grant_q <= grant_new_d;
                        gidx_q  <= win_d;
                        hex_q   <= glyph_d;
                        cnt_q   <= HOLD_LOAD;
                    end
                end
                SHOW: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        ptr_q <= next_ptr_d;
                        if (found_d) begin
                            grant_q <= grant_new_d;
                            gidx_q  <= win_d;
                            hex_q   <= glyph_d;
                            cnt_q   <= HOLD_LOAD;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            hex_q   <= BLANK;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.LEDR  = grant_q;
    assign bus.busy  = |grant_q;
    assign bus.HEX5  = hex_q;
endmodule

// File: tb/tb_hex5_display_arbiter.sv
// Bench for hex5_display_arbiter: a HOLD=4 instance and a HOLD=1 instance share clock and reset.
// Latency: expected grant/glyph per cycle are queued when stimulus is applied, popped each edge.
// Backpressure: n/a.
module tb_hex5_display_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [6:0] h;
    } exp_t;

    exp_t sb[$];

    localparam logic [6:0] BL = 7'b1111111;

    hex5_display_arbiter_if #(.NREQ(4)) ifa ();
    hex5_display_arbiter_if #(.NREQ(4)) ifb ();

    hex5_display_arbiter #(.NREQ(4), .HOLD_CYCLES(4)) dut_a (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (ifa)
    );

    hex5_display_arbiter #(.NREQ(4), .HOLD_CYCLES(1)) dut_b (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (ifb)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [3:0] g, input logic [6:0] h, input int n);
        exp_t e;
        e.g = g;
        e.h = h;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ifa.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want %b", ifa.grant, 4'b0000); end
        checks++; if (ifa.HEX5 !== BL) begin errors++; $display("FAIL reset_hex got %b want %b", ifa.HEX5, BL); end
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", ifa.busy); end
        checks++; if (ifa.LEDR !== 4'b0000) begin errors++; $display("FAIL reset_ledr got %b want %b", ifa.LEDR, 4'b0000); end
        checks++; if (ifb.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant_b got %b want %b", ifb.grant, 4'b0000); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_all_req;
        exp_t e;
        int   n;
        n = 0;
        ifa.digit = 16'hC5A8;
        ifa.req   = 4'b1111;
        push(4'b0001, 7'b0000000, 4);
        push(4'b0010, 7'b0001000, 4);
        push(4'b0100, 7'b0010010, 4);
        push(4'b1000, 7'b1000110, 4);
        push(4'b0001, 7'b0000000, 4);
        push(4'b0000, BL, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            checks++; if (ifa.grant !== e.g) begin errors++; $display("FAIL all_req_grant[%0d] got %b want %b", n, ifa.grant, e.g); end
            checks++; if (ifa.HEX5 !== e.h) begin errors++; $display("FAIL all_req_hex[%0d] got %b want %b", n, ifa.HEX5, e.h); end
            checks++; if (ifa.busy !== (e.g != 4'b0000)) begin errors++; $display("FAIL all_req_busy[%0d] got %b want %b", n, ifa.busy, (e.g != 4'b0000)); end
            checks++; if (ifa.LEDR !== e.g) begin errors++; $display("FAIL all_req_ledr[%0d] got %b want %b", n, ifa.LEDR, e.g); end
            if (n == 16) ifa.req = 4'b0000;
            n++;
        end
    endtask

    task automatic test_single;
        exp_t e;
        int   n;
        n = 0;
        ifa.digit = 16'h0010;
        ifa.req   = 4'b0010;
        push(4'b0010, 7'b1111001, 4);
        push(4'b0000, BL, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            checks++; if (ifa.grant !== e.g) begin errors++; $display("FAIL single_grant[%0d] got %b want %b", n, ifa.grant, e.g); end
            checks++; if (ifa.HEX5 !== e.h) begin errors++; $display("FAIL single_hex[%0d] got %b want %b", n, ifa.HEX5, e.h); end
            checks++; if (ifa.busy !== (e.g != 4'b0000)) begin errors++; $display("FAIL single_busy[%0d] got %b want %b", n, ifa.busy, (e.g != 4'b0000)); end
            if (n == 0) ifa.req = 4'b0000;
            n++;
        end
    endtask

    task automatic test_pointer_fairness;
        exp_t e;
        int   n;
        n = 0;
        ifa.digit = 16'h3210;
        ifa.req   = 4'b0100;
        push(4'b0100, 7'b0100100, 4);
        push(4'b0000, BL, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            checks++; if (ifa.grant !== e.g) begin errors++; $display("FAIL fair_setup_grant[%0d] got %b want %b", n, ifa.grant, e.g); end
            checks++; if (ifa.HEX5 !== e.h) begin errors++; $display("FAIL fair_setup_hex[%0d] got %b want %b", n, ifa.HEX5, e.h); end
            if (n == 0) ifa.req = 4'b0000;
            n++;
        end
        n = 0;
        ifa.req = 4'b1010;
        push(4'b1000, 7'b0110000, 4);
        push(4'b0010, 7'b1111001, 4);
        push(4'b0000, BL, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            checks++; if (ifa.grant !== e.g) begin errors++; $display("FAIL fair_grant[%0d] got %b want %b", n, ifa.grant, e.g); end
            checks++; if (ifa.HEX5 !== e.h) begin errors++; $display("FAIL fair_hex[%0d] got %b want %b", n, ifa.HEX5, e.h); end
            if (n == 4) ifa.req = 4'b0000;
            n++;
        end
    endtask

    task automatic test_hold_immunity;
        exp_t e;
        int   n;
        n = 0;
        ifa.digit = 16'h0008;
        ifa.req   = 4'b0001;
        push(4'b0001, 7'b0000000, 4);
        push(4'b0000, BL, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            checks++; if (ifa.grant !== e.g) begin errors++; $display("FAIL immune_grant[%0d] got %b want %b", n, ifa.grant, e.g); end
            checks++; if (ifa.HEX5 !== e.h) begin errors++; $display("FAIL immune_hex[%0d] got %b want %b", n, ifa.HEX5, e.h); end
            if (n == 0) begin
                ifa.req   = 4'b0000;
                ifa.digit = 16'h000F;
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_hold;
        exp_t e;
        int   n;
        n = 0;
        ifa.digit = 16'h0A00;
        ifa.req   = 4'b0100;
        push(4'b0100, 7'b0001000, 2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            checks++; if (ifa.grant !== e.g) begin errors++; $display("FAIL midrst_pre_grant[%0d] got %b want %b", n, ifa.grant, e.g); end
            checks++; if (ifa.HEX5 !== e.h) begin errors++; $display("FAIL midrst_pre_hex[%0d] got %b want %b", n, ifa.HEX5, e.h); end
            n++;
        end
        rst       = 1'b1;
        ifa.req   = 4'b1000;
        ifa.digit = 16'h3A00;
        #1;
        checks++; if (ifa.grant !== 4'b0000) begin errors++; $display("FAIL midrst_grant got %b want %b", ifa.grant, 4'b0000); end
        checks++; if (ifa.HEX5 !== BL) begin errors++; $display("FAIL midrst_hex got %b want %b", ifa.HEX5, BL); end
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", ifa.busy); end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        push(4'b1000, 7'b0110000, 4);
        push(4'b0000, BL, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            checks++; if (ifa.grant !== e.g) begin errors++; $display("FAIL midrst_post_grant[%0d] got %b want %b", n, ifa.grant, e.g); end
            checks++; if (ifa.HEX5 !== e.h) begin errors++; $display("FAIL midrst_post_hex[%0d] got %b want %b", n, ifa.HEX5, e.h); end
            if (n == 0) ifa.req = 4'b0000;
            n++;
        end
    endtask

    task automatic test_min_hold;
        exp_t e;
        int   n;
        n = 0;
        ifb.digit = 16'h0704;
        ifb.req   = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            push(4'b0001, 7'b0011001, 1);
            push(4'b0100, 7'b1111000, 1);
        end
        push(4'b0000, BL, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            checks++; if (ifb.grant !== e.g) begin errors++; $display("FAIL minhold_grant[%0d] got %b want %b", n, ifb.grant, e.g); end
            checks++; if (ifb.HEX5 !== e.h) begin errors++; $display("FAIL minhold_hex[%0d] got %b want %b", n, ifb.HEX5, e.h); end
            checks++; if (ifb.busy !== (e.g != 4'b0000)) begin errors++; $display("FAIL minhold_busy[%0d] got %b want %b", n, ifb.busy, (e.g != 4'b0000)); end
            if (n == 5) ifb.req = 4'b0000;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        ifa.req   = '0;
        ifa.digit = '0;
        ifb.req   = '0;
        ifb.digit = '0;
        test_reset();
        test_all_req();
        test_single();
        test_pointer_fairness();
        test_hold_immunity();
        test_reset_mid_hold();
        test_min_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hex5_display_arbiter.md
# hex5_display_arbiter

Round-robin arbiter that shares the single HEX5 seven-segment display and the LEDR grant indicators among NREQ requesters. Each requester presents a 4-bit digit and a request. The arbiter grants the display to one requester at a time for a fixed hold window, latches that requester's digit, and drives the decoded active-low glyph onto HEX5. It sits between the lab's per-function logic blocks and the board display pins, replacing direct writes to HEX5.

## Interface

- NREQ, 4, number of requesters; must be ≥ 2.
- HOLD_CYCLES, 25_000_000, clock cycles each grant is held (0.5 s at 50 MHz); must be ≥ 1.

- CLOCK_50  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  request lines; bit i belongs to requester i.
- digit  input  4*NREQ  requester i's digit on bits [4i+3:4i].
- grant  output  NREQ  one-hot grant, registered; all zero when idle.
- busy  output  1  high while any grant is active (OR of grant).
- HEX5  output  7  active-low segments, ordered {g,f,e,d,c,b,a}, registered.
- LEDR  output  NREQ  mirrors grant.

## Operation

- Reset values:
  - grant = 0, busy = 0, LEDR = 0.
  - HEX5 = 7'b1111111 (blank).
  - Round-robin pointer ptr = 0, hold counter = 0, state = IDLE.
- States:
  - IDLE: no grant, HEX5 blank.
  - SHOW: exactly one grant bit set.
- Arbitration, at any edge where a new grant is chosen:
  - Scan requesters ptr, ptr+1, …, wrapping mod NREQ.
  - Grant the first one with req high.
  - Latch its digit into the display register.
  - Load the counter with HOLD_CYCLES-1.
- IDLE → SHOW: at an edge where any req bit is high, perform arbitration.
- SHOW counting: the counter decrements each cycle while nonzero.
- End of hold, at the edge where the counter is 0:
  - ptr ← (granted index + 1) mod NREQ.
  - If any req is high, re-arbitrate with the updated ptr and stay in SHOW. There is no idle gap, and the same requester may be re-granted if it is the only one requesting.
  - Otherwise go to IDLE: grant ← 0, HEX5 ← blank.
- During SHOW:
  - req and digit are ignored.
  - Dropping req does not shorten the grant.
  - Digit changes do not alter HEX5.
- Decode: standard hex glyphs 0-9, A, b, C, d, E, F, active-low. Required values:
  - 0 → 7'b1000000
  - 1 → 7'b1111001
  - 8 → 7'b0000000
  - A → 7'b0001000
  - F → 7'b0001110
- Reset asserted mid-hold: all outputs return to reset values immediately (asynchronously), and ptr returns to 0.

## Timing

- Grant latency: req sampled high at edge k (in IDLE) → grant, LEDR, busy and HEX5 valid after edge k. No combinational path from req to any output.
- Each grant is held for exactly HOLD_CYCLES clock cycles.
- Back-to-back grants are contiguous: the new grant bit is set in the same cycle the old one clears.
- HOLD_CYCLES = 1: a different requester may be granted every cycle, while round-robin order is still honored.
- HEX5 changes only on edges where a grant starts or the arbiter enters IDLE.
- Reset deassertion: the first arbitration happens at the first rising edge after reset falls.

## Test plan

Use NREQ = 4 and HOLD_CYCLES = 4 unless stated otherwise.

- Reset:
  - Stimulus: assert reset during an active grant of requester 2 with digit 4'hA.
  - Required: grant = 0, HEX5 = 7'b1111111 and busy = 0 immediately, without waiting for a clock edge.
  - After release with only req[3] high: requester 3 is granted (ptr restarted at 0).
- Single request:
  - Stimulus: req = 4'b0010, digit[7:4] = 4'h1.
  - Required: grant = 4'b0010 and HEX5 = 7'b1111001 after the sampling edge, held 4 cycles.
  - If req then drops: IDLE, HEX5 = 7'b1111111.
- All requesting:
  - Stimulus: req = 4'b1111 held.
  - Required: grants 0, 1, 2, 3, 0 in order, each exactly 4 cycles, no gap cycles, busy continuously high.
- Pointer fairness:
  - Stimulus: after requester 2's grant ends, req = 4'b1010.
  - Required: requester 3 is granted first, then requester 1.
- Hold immunity:
  - Stimulus: during requester 0's grant with digit 4'h8 latched, drop req[0] and change digit[3:0] to 4'hF.
  - Required: grant persists all 4 cycles and HEX5 stays 7'b0000000.
- Minimum hold:
  - Stimulus: HOLD_CYCLES = 1, req = 4'b0101.
  - Required: grant alternates 4'b0001 and 4'b0100 every cycle.
